// File: rtl/ras_if.sv
// ras_if: control, prediction and checkpoint bundle between the branch predictor and the return-address stack.
interface ras_if #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);
  logic             flush;
  logic             valid;
  logic [1:0]       ras_ctl;
  logic [VLEN-1:0]  push_addr;
  logic             pred_valid;
  logic [VLEN-1:0]  pred_addr;
  logic [PTR_W-1:0] ckpt_tos;
  logic [PTR_W:0]   ckpt_cnt;
  logic             restore;
  logic [PTR_W-1:0] restore_tos;
  logic [PTR_W:0]   restore_cnt;
  logic             empty;
  logic             full;
  modport master (
    output flush, valid, ras_ctl, push_addr, restore, restore_tos, restore_cnt,
    input  pred_valid, pred_addr, ckpt_tos, ckpt_cnt, empty, full
  );
  modport slave (
    input  flush, valid, ras_ctl, push_addr, restore, restore_tos, restore_cnt,
    output pred_valid, pred_addr, ckpt_tos, ckpt_cnt, empty, full
  );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with checkpoint/restore for misprediction recovery.
module ras_stack #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 8
) (
  input logic  clk_i,
  input logic  rst_ni,
  ras_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  logic [VLEN-1:0]  entries [DEPTH];
  logic [PTR_W-1:0] tos, tos_inc, tos_dec;
  logic [PTR_W:0]   cnt;
  logic             empty, full, op, push, pop, swap;
  always_comb begin
    tos_inc = tos + 1'b1;
    tos_dec = tos - 1'b1;
    empty   = cnt == '0;
    full    = cnt == FULL_CNT;
    op      = bus.valid && !bus.flush && !bus.restore;
    push    = op && bus.ras_ctl == 2'b00;
    pop     = op && bus.ras_ctl == 2'b01;
    swap    = op && bus.ras_ctl == 2'b10;
  end
  assign bus.pred_valid = (pop || swap) && !empty;
  assign bus.pred_addr  = entries[tos];
  assign bus.ckpt_tos   = tos;
  assign bus.ckpt_cnt   = cnt;
  assign bus.empty      = empty;
  assign bus.full       = full;
  // A push on a full stack wraps onto the oldest slot; cnt saturates.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tos     <= '0;
      cnt     <= '0;
      entries <= '{default: '0};
    end else if (bus.flush) begin
      tos <= '0;
      cnt <= '0;
    end else if (bus.restore) begin
      tos <= bus.restore_tos;
      cnt <= bus.restore_cnt;
    end else if (push) begin
      tos              <= tos_inc;
      entries[tos_inc] <= bus.push_addr;
      cnt              <= full ? cnt : cnt + 1'b1;
    end else if (pop && !empty) begin
      tos <= tos_dec;
      cnt <= cnt - 1'b1;
    end else if (swap) begin
      entries[tos] <= bus.push_addr;
      cnt          <= empty ? (PTR_W+1)'(1) : cnt;
    end
endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return-address stack inside the front-end branch predictor.
- Driven by the decoded branch-predictor control: `bp_ctl_t.ras_ctl` encodes 00 push, 01 pop, 10 push+pop, 11 no-op.
- Produces the RAS half of `bp_result_t` (pred_valid / pred_add) for returns.
- Exports a pointer/count checkpoint per prediction so the backend can roll the stack back on misprediction.

Parameters:
- VLEN, 64, virtual address width (matches config_pkg::VLEN).
- DEPTH, 8, number of stack entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), top-of-stack pointer width (derived, not overridden).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  front-end flush; empties the stack.
- valid_i  input  1  a bp_ctl_t with bp_ctl_i==2'b10 (RAS selected) is presented this cycle.
- ras_ctl_i  input  2  00 push, 01 pop, 10 push+pop, 11 no-op.
- push_addr_i  input  VLEN  return address to push (call pc + 4, or + 2 for compressed).
- pred_valid_o  output  1  RAS prediction valid (pop or push+pop with non-empty stack).
- pred_addr_o  output  VLEN  predicted return target.
- ckpt_tos_o  output  PTR_W  current top-of-stack pointer, to carry with the instruction.
- ckpt_cnt_o  output  PTR_W+1  current occupancy, to carry with the instruction.
- restore_i  input  1  misprediction recovery request.
- restore_tos_i  input  PTR_W  checkpointed top-of-stack pointer to restore.
- restore_cnt_i  input  PTR_W+1  checkpointed occupancy to restore.
- empty_o  output  1  count == 0.
- full_o  output  1  count == DEPTH.

Behaviour:
- State:
  - entries[DEPTH] of VLEN.
  - tos: PTR_W pointer to the current top entry.
  - cnt: 0..DEPTH.
- Reset (async, rst_ni low):
  - tos=0, cnt=0, all entries=0.
  - pred_valid_o=0, pred_addr_o=0, empty_o=1, full_o=0, ckpt_tos_o=0, ckpt_cnt_o=0.
- Outputs are combinational from the current registered state; zero-cycle latency.
  - pred_addr_o = entries[tos].
  - pred_valid_o = valid_i && (ras_ctl_i==01 || ras_ctl_i==10) && cnt!=0 && !flush_i && !restore_i.
  - ckpt_tos_o / ckpt_cnt_o = state before this cycle's update.
- Updates on the rising clock edge when valid_i=1, in priority order flush_i > restore_i > valid_i op.
- push (00):
  - tos <= tos+1 (mod DEPTH), entries[tos+1] <= push_addr_i, cnt <= min(cnt+1, DEPTH).
  - When full, the push wraps and overwrites the oldest entry; cnt stays DEPTH.
- pop (01):
  - If cnt!=0: tos <= tos-1 (mod DEPTH), cnt <= cnt-1.
  - If cnt==0: no state change, pred_valid_o=0.
- push+pop (10):
  - Prediction uses the old top.
  - entries[tos] <= push_addr_i; tos unchanged.
  - cnt <= (cnt==0) ? 1 : cnt.
- no-op (11), or valid_i=0: no change.
- restore_i: tos <= restore_tos_i, cnt <= restore_cnt_i. Entry contents are not rolled back. Any concurrent valid_i op is dropped.
- flush_i: tos <= 0, cnt <= 0, entries untouched. Overrides restore_i and valid_i in the same cycle.
- restore_cnt_i > DEPTH is illegal; the bench asserts it never occurs.
- Pointer arithmetic is modulo DEPTH (natural PTR_W wrap); cnt never exceeds DEPTH and never underflows.
- Reset asserted mid-operation clears the state immediately, regardless of clock.

Test Plan:
- Reset, then push A=0x1000, B=0x2000, C=0x3000, then three pops -> pred_addr_o 0x3000, 0x2000, 0x1000 with pred_valid_o=1; afterwards empty_o=1.
- Pop on an empty stack -> pred_valid_o=0; tos and cnt unchanged; empty_o stays 1.
- DEPTH=8: push 0x100..0x900 (9 pushes) -> full_o=1, cnt=8; eight pops return 0x900 down to 0x200; a ninth pop gives pred_valid_o=0.
- Push 0x40, then push+pop with 0x80 -> pred_addr_o=0x40 valid; cnt stays 1; next pop returns 0x80.
- Push 0xA0 (checkpoint tos=1,cnt=1), push 0xB0, pop, pop; then restore_i with tos=1,cnt=1 -> next pop returns 0xA0 valid.
- Same cycle flush_i=1, restore_i=1, valid_i=1 push -> after the edge cnt=0 and empty_o=1; assert rst_ni low mid-sequence -> all outputs at reset values immediately.
